// File: rtl/ascon_pack.sv
// Shared ASCON types and constants: 320-bit state as five 64-bit words (index 0 = x0),
// round bounds and the permutation FSM encoding.
package ascon_pack;
  typedef logic [4:0][63:0] type_state;

  localparam logic [3:0] ROUND_LAST = 4'hB;
  localparam logic [3:0] P6_FIRST   = 4'h6;

  typedef enum logic [1:0] {IDLE, RUN, DONE} type_fsm;

  function automatic logic [63:0] rotr(input logic [63:0] x, input int unsigned n);
    return (x >> n) | (x << (64 - n));
  endfunction
endpackage

// File: rtl/ascon_layers.sv
// ASCON round layers (pc, ps, pl), purely combinational.
// Zero latency, no flow control.
module constant_addition
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);
  // {~r, r} equals 8'hF0 - r*8'h0F for every 4-bit r.
  always_comb begin
    state_o    = state_i;
    state_o[2] = state_i[2] ^ {56'h0, ~round_i, round_i};
  end
endmodule

module substitution_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);
  logic [63:0] a0, a1, a2, a3, a4;
  logic [63:0] b0, b1, b2, b3, b4;

  // Bitsliced 5-bit S-box applied to all 64 columns at once.
  assign a0 = state_i[0] ^ state_i[4];
  assign a1 = state_i[1];
  assign a2 = state_i[2] ^ state_i[1];
  assign a3 = state_i[3];
  assign a4 = state_i[4] ^ state_i[3];

  assign b0 = a0 ^ (~a1 & a2);
  assign b1 = a1 ^ (~a2 & a3);
  assign b2 = a2 ^ (~a3 & a4);
  assign b3 = a3 ^ (~a4 & a0);
  assign b4 = a4 ^ (~a0 & a1);

  assign state_o[0] = b0 ^ b4;
  assign state_o[1] = b1 ^ b0;
  assign state_o[2] = ~b2;
  assign state_o[3] = b3 ^ b2;
  assign state_o[4] = b4;
endmodule

module diffusion_layer
  import ascon_pack::*;
(
  input  type_state state_i,
  output type_state state_o
);
  assign state_o[0] = state_i[0] ^ rotr(state_i[0], 19) ^ rotr(state_i[0], 28);
  assign state_o[1] = state_i[1] ^ rotr(state_i[1], 61) ^ rotr(state_i[1], 39);
  assign state_o[2] = state_i[2] ^ rotr(state_i[2], 1)  ^ rotr(state_i[2], 6);
  assign state_o[3] = state_i[3] ^ rotr(state_i[3], 10) ^ rotr(state_i[3], 17);
  assign state_o[4] = state_i[4] ^ rotr(state_i[4], 7)  ^ rotr(state_i[4], 41);
endmodule

// File: rtl/permutation_iter_round_comb.sv
// One full ASCON round: pc -> ps -> pl chained combinationally.
// Zero latency, no flow control.
module round_comb
  import ascon_pack::*;
(
  input  type_state  state_i,
  input  logic [3:0] round_i,
  output type_state  state_o
);
  type_state pc_out;
  type_state ps_out;

  constant_addition u_pc (
    .state_i (state_i),
    .round_i (round_i),
    .state_o (pc_out)
  );

  substitution_layer u_ps (
    .state_i (pc_out),
    .state_o (ps_out)
  );

  diffusion_layer u_pl (
    .state_i (ps_out),
    .state_o (state_o)
  );
endmodule

// File: rtl/permutation_iter.sv
// Iterative ASCON p12/p6 engine: one round per cycle, done pulses N cycles after the load edge.
// start_i is only honoured in IDLE or DONE; requests during RUN are dropped.
module permutation_iter
  import ascon_pack::*;
(
  input  logic       clock_i,
  input  logic       resetb_i,
  input  logic       start_i,
  input  logic       mode_i,
  input  type_state  state_i,
  output type_state  state_o,
  output logic [3:0] round_o,
  output logic       busy_o,
  output logic       done_o
);
  type_fsm    fsm;
  type_state  state_reg;
  type_state  state_nxt;
  logic [3:0] cnt;

  round_comb u_round (
    .state_i (state_reg),
    .round_i (cnt),
    .state_o (state_nxt)
  );

  assign state_o = state_reg;
  assign round_o = cnt;
  assign busy_o  = (fsm == RUN);
  assign done_o  = (fsm == DONE);

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      fsm       <= IDLE;
      state_reg <= '0;
      cnt       <= 4'h0;
    end else begin
      case (fsm)
        IDLE, DONE: begin
          if (start_i) begin
            state_reg <= state_i;
            cnt       <= mode_i ? P6_FIRST : 4'h0;
            fsm       <= RUN;
          end else begin
            fsm <= IDLE;
          end
        end
        RUN: begin
          state_reg <= state_nxt;
          // Counter parks on the last round so round_o stays meaningful in DONE.
          if (cnt == ROUND_LAST) fsm <= DONE;
          else                   cnt <= cnt + 4'h1;
        end
        default: fsm <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_permutation_iter.sv
// Directed + randomized bench for permutation_iter against a table-driven ASCON model.
module tb_permutation_iter;
  import ascon_pack::*;

  logic       clock_i = 1'b0;
  logic       resetb_i;
  logic       start_i;
  logic       mode_i;
  type_state  state_i;
  type_state  state_o;
  logic [3:0] round_o;
  logic       busy_o;
  logic       done_o;

  int checks = 0;
  int errors = 0;

  logic [4:0] sbox_tab [32] = '{
    5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
    5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
    5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
    5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

  permutation_iter dut (
    .clock_i  (clock_i),
    .resetb_i (resetb_i),
    .start_i  (start_i),
    .mode_i   (mode_i),
    .state_i  (state_i),
    .state_o  (state_o),
    .round_o  (round_o),
    .busy_o   (busy_o),
    .done_o   (done_o)
  );

  always #5 clock_i = ~clock_i;

  function automatic logic [63:0] ror(input logic [63:0] x, input int n);
    return (x >> n) | (x << (64 - n));
  endfunction

  function automatic type_state model_round(input type_state s, input int r);
    type_state  t;
    logic [7:0] c;
    logic [4:0] idx;
    logic [4:0] o;
    c = 8'hF0 - 8'(r) * 8'h0F;
    s[2] = s[2] ^ {56'h0, c};
    for (int b = 0; b < 64; b++) begin
      idx = {s[0][b], s[1][b], s[2][b], s[3][b], s[4][b]};
      o = sbox_tab[idx];
      t[0][b] = o[4];
      t[1][b] = o[3];
      t[2][b] = o[2];
      t[3][b] = o[1];
      t[4][b] = o[0];
    end
    s[0] = t[0] ^ ror(t[0], 19) ^ ror(t[0], 28);
    s[1] = t[1] ^ ror(t[1], 61) ^ ror(t[1], 39);
    s[2] = t[2] ^ ror(t[2], 1)  ^ ror(t[2], 6);
    s[3] = t[3] ^ ror(t[3], 10) ^ ror(t[3], 17);
    s[4] = t[4] ^ ror(t[4], 7)  ^ ror(t[4], 41);
    return s;
  endfunction

  function automatic type_state model_perm(input type_state s, input logic mode);
    int first;
    first = mode ? 6 : 0;
    for (int r = first; r <= 11; r++) s = model_round(s, r);
    return s;
  endfunction

  function automatic type_state rand_state();
    type_state s;
    for (int w = 0; w < 5; w++) s[w] = {$urandom, $urandom};
    return s;
  endfunction

  task automatic chk(input string tag, input logic [319:0] obs, input logic [319:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drives start on the current negedge; returns at the negedge where done_o should be high.
  task automatic run_perm(input logic mode, input type_state st, input int ignore_at,
                          output type_state res);
    int        first;
    int        n;
    type_state exp;
    first = mode ? 6 : 0;
    n     = 12 - first;
    exp   = model_perm(st, mode);
    start_i = 1'b1;
    mode_i  = mode;
    state_i = st;
    @(negedge clock_i);
    start_i = 1'b0;
    mode_i  = 1'($urandom);
    state_i = rand_state();
    chk("load_round", round_o, first);
    chk("load_busy", busy_o, 1);
    chk("load_done", done_o, 0);
    for (int j = 1; j <= n; j++) begin
      if (j == ignore_at) begin
        start_i = 1'b1;
        mode_i  = ~mode;
        state_i = rand_state();
      end
      @(negedge clock_i);
      start_i = 1'b0;
      if (j < n) begin
        chk("run_round", round_o, first + j);
        chk("run_busy", busy_o, 1);
        chk("run_done", done_o, 0);
      end else begin
        chk("done_pulse", done_o, 1);
        chk("done_busy", busy_o, 0);
        chk("done_round", round_o, 11);
        chk("result", state_o, exp);
      end
    end
    res = exp;
  endtask

  initial begin
    type_state gold_in;
    type_state res;
    type_state st;
    logic      md;

    gold_in[0] = 64'h80400c0600000000;
    gold_in[1] = 64'h8a55114d1cb6a9a2;
    gold_in[2] = 64'hbe263d4d7aecaa0f;
    gold_in[3] = 64'h4ed0ec0b98c529b7;
    gold_in[4] = 64'hc8cddf37bcd0284a;

    resetb_i = 1'b0;
    start_i  = 1'b0;
    mode_i   = 1'b0;
    state_i  = '0;
    #12;
    chk("rst_state", state_o, 0);
    chk("rst_round", round_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    @(negedge clock_i);
    resetb_i = 1'b1;
    @(negedge clock_i);

    // p12 on the reference vector.
    run_perm(1'b0, gold_in, 0, res);
    @(negedge clock_i);
    chk("post_done_clear", done_o, 0);
    chk("post_done_busy", busy_o, 0);

    // p6 on the reference vector.
    run_perm(1'b1, gold_in, 0, res);

    // Idle hold: result must stay put with no start.
    for (int i = 0; i < 20; i++) begin
      @(negedge clock_i);
      chk("idle_state", state_o, res);
      chk("idle_busy", busy_o, 0);
      chk("idle_done", done_o, 0);
    end

    // Start pulse with different inputs while at round 3 must be ignored.
    run_perm(1'b0, gold_in, 4, res);
    @(negedge clock_i);

    // Back-to-back: next start presented during the DONE cycle.
    run_perm(1'b0, rand_state(), 0, res);
    run_perm(1'b1, rand_state(), 0, res);
    run_perm(1'b0, rand_state(), 0, res);

    // Randomized runs with random gaps (gap 0 is back-to-back).
    for (int k = 0; k < 8; k++) begin
      st = rand_state();
      md = 1'($urandom);
      run_perm(md, st, int'($urandom_range(0, 14)), res);
      repeat ($urandom_range(0, 2)) @(negedge clock_i);
    end

    // Reset during RUN at round 5 aborts immediately.
    start_i = 1'b1;
    mode_i  = 1'b0;
    state_i = gold_in;
    @(negedge clock_i);
    start_i = 1'b0;
    repeat (5) @(negedge clock_i);
    chk("pre_rst_round", round_o, 5);
    resetb_i = 1'b0;
    #1;
    chk("abort_state", state_o, 0);
    chk("abort_round", round_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_done", done_o, 0);
    @(negedge clock_i);
    resetb_i = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(negedge clock_i);
      chk("post_rst_busy", busy_o, 0);
      chk("post_rst_done", done_o, 0);
      chk("post_rst_state", state_o, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/permutation_iter.md
Name: permutation_iter

Overview:
- Iterative ASCON permutation engine (p12 / p6). It sits directly upstream of constant_addition and feeds it every round.
- Holds the 320-bit state register and the round counter. Each cycle it drives round_i and state_i of constant_addition, then the substitution and linear layers, and writes the result back.
- A start/done handshake connects it to the mode FSM (init, associated data, plaintext, finalisation).

Parameters:
- ROUND_LAST, 4'hB, index of the final round (11). Fixed by ASCON; do not override.
- P6_FIRST, 4'h6, first round index in p6 mode.

Ports:
- clock_i  in  1  system clock, rising edge.
- resetb_i  in  1  asynchronous active-low reset.
- start_i  in  1  request a permutation. Sampled only in IDLE or DONE.
- mode_i  in  1  0 = p12 (rounds 0..11), 1 = p6 (rounds 6..11). Sampled with start_i.
- state_i  in  type_state (5x64)  state to permute. Sampled with start_i.
- state_o  out  type_state  state register contents.
- round_o  out  4  current round index driven to constant_addition.
- busy_o  out  1  high in RUN.
- done_o  out  1  one-cycle pulse: state_o holds the permuted result.

Behaviour:
- Reset (async, resetb_i=0):
  - FSM -> IDLE.
  - State register = all 5 words 64'h0.
  - Round counter = 4'h0.
  - busy_o = 0, done_o = 0, round_o = 0, state_o = 0.
  - Reset asserted mid-RUN aborts immediately. No done_o is produced.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - start_i=1 at an edge: state_reg <= state_i; cnt <= (mode_i ? P6_FIRST : 0); go to RUN.
  - start_i=0: hold, and state_o keeps its last value.
- RUN, at each edge:
  - state_reg <= pl(ps(pc(state_reg, cnt))).
  - If cnt == ROUND_LAST: go to DONE and leave cnt unchanged. Otherwise cnt <= cnt+1.
  - start_i, mode_i and state_i are ignored in RUN.
- DONE (exactly one cycle):
  - done_o=1; state_o = final result.
  - start_i=1 at this edge is accepted as in IDLE (back-to-back), going to RUN. Otherwise go to IDLE.
- round_o = cnt, combinationally, in all states. The pc stage uses round_o: x2 ^= {56'h0, ~cnt, cnt}, i.e. the constant for round r is 8'hF0 - r*8'h0F.
- Timing, with start sampled at edge k:
  - Round r=first is applied at edge k+1.
  - For N rounds (12 or 6), the last round is applied at edge k+N.
  - done_o is high between edges k+N and k+N+1.
  - Start-to-done latency: p12 = 12 cycles, p6 = 6 cycles after the load edge.
- busy_o = 1 exactly N cycles per permutation.
- Counter arithmetic: 4-bit. It never passes ROUND_LAST, so no wrap-around occurs.
- state_o holds the result until the next accepted start. It changes every cycle during RUN, and intermediate values are observable but carry no meaning.
- If start_i is held high continuously: permutations run back-to-back. Each new state_i is sampled on the DONE edge, giving period N+1 cycles.

Decomposition:
- ascon_pack (shared package):
  - type_state (array of 5 logic [63:0]).
  - ROUND_LAST and P6_FIRST constants.
  - Enum for FSM states {IDLE, RUN, DONE}.
- Reused combinational blocks: existing constant_addition, substitution_layer, diffusion_layer.
- One new sub-module, round_comb: a combinational chain of the three layers with ports state_i, round_i, state_o. permutation_iter instantiates round_comb once and contains only the register, counter and FSM.

Test Plan:
- Reset check: resetb_i=0 mid-RUN at round 5 -> state_o=0, round_o=0, busy_o=0, done_o=0 immediately (before any clock edge). After release, the engine idles until start_i.
- p12 run: state_i = {80400c0600000000, 8a55114d1cb6a9a2, be263d4d7aecaa0f, 4ed0ec0b98c529b7, c8cddf37bcd0284a}, mode_i=0.
  - round_o steps 0..11 on successive cycles.
  - One cycle after the load edge, x2 has passed through pc with 8'hF0: pc-stage value be263d4d7aecaaff.
  - done_o pulses once, 12 cycles after the load edge.
  - state_o equals the golden p12 output from the team software model.
- p6 run: same state_i, mode_i=1.
  - round_o = 6,7,8,9,10,11.
  - Constants 96,87,78,69,5a,4b.
  - done_o 6 cycles after load; state_o matches the golden p6 output.
- Start ignored in RUN: pulse start_i with a different state_i at round 3 -> sequence, done_o timing and result are unaffected.
- Back-to-back: start_i held high across the DONE cycle with a new state_i -> new load on the DONE edge. The second done_o arrives N+1 cycles after the first. Both results match golden.
- Idle hold: no start for 20 cycles after DONE -> state_o stable, busy_o=0, done_o=0.
